// File: rtl/controlador_partida_pkg.sv
// Shared definitions for the game controller: state encoding, shot-clock
// length, horn length and the game-clock width.
package controlador_partida_pkg;

  typedef enum logic [2:0] {
    PARADO     = 3'd0,
    CORRENDO   = 3'd1,
    PAUSADO    = 3'd2,
    VIOLACAO   = 3'd3,
    FIM_QUARTO = 3'd4,
    FIM_JOGO   = 3'd5
  } estado_t;

  localparam int TEMPO_POSSE   = 24;
  localparam int BUZZER_CICLOS = 3;
  localparam int TEMPO_W       = 10;

  // True when the FSM is about to enter one of the states that sound the horn.
  function automatic logic evento_buzzer(input estado_t atual, input estado_t proximo);
    return (proximo != atual) && (proximo inside {VIOLACAO, FIM_QUARTO, FIM_JOGO});
  endfunction

endpackage

// File: rtl/controlador_partida_cronometro.sv
// cronometro_jogo: game-clock down-counter. Loads the period length on reset
// or on request, counts down on enable and saturates at zero.
module cronometro_jogo
  import controlador_partida_pkg::*;
#(
  parameter int PERIODO_SEG = 600
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               i_carga,
  input  logic               i_dec,
  output logic [TEMPO_W-1:0] o_valor,
  output logic               o_zero
);

  localparam logic [TEMPO_W-1:0] VALOR_CARGA = TEMPO_W'(PERIODO_SEG);

  logic [TEMPO_W-1:0] r_valor;

  // Reload has priority over counting; the count stops at zero instead of wrapping.
  always_ff @(posedge clock_in) begin
    if (reset || i_carga) begin
      r_valor <= VALOR_CARGA;
    end else if (i_dec && (r_valor != '0)) begin
      r_valor <= r_valor - 1'b1;
    end
  end

  assign o_valor = r_valor;
  assign o_zero  = (r_valor == '0);

endmodule

// File: rtl/controlador_partida.sv
// controlador_partida: basketball game controller. Sequences periods, drives
// the shot-clock control lines and the horn.
// Optional macro DESLIGA_POSSE_EN: switches the shot clock off when less game
// time remains than the shot clock shows (and below 24 s).
module controlador_partida
  import controlador_partida_pkg::*;
#(
  parameter int PERIODO_SEG = 600,
  parameter int NUM_QUARTOS = 4
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       troca_posse,
  input  logic [4:0] contagem24,
  output logic       en24,
  output logic       parar24,
  output logic       reset24,
  output logic [9:0] tempo_jogo,
  output logic [1:0] quarto,
  output logic [2:0] estado,
  output logic       buzzer
);

  localparam logic [1:0] ULTIMO_QUARTO = 2'(NUM_QUARTOS - 1);
  localparam logic [1:0] BUZZER_CARGA  = 2'(BUZZER_CICLOS);

  estado_t            r_estado;
  estado_t            w_proximo;
  logic [1:0]         r_quarto;
  logic               r_reset24;
  logic [1:0]         r_buzzCnt;
  logic [TEMPO_W-1:0] w_tempo;
  logic               w_tempoZero;
  logic               w_posseDesligada;
  logic               w_carregaTempo;
  logic               w_decTempo;
  logic               w_avancaQuarto;
  logic               w_pulso24;
  logic               w_comeca;

  cronometro_jogo #(
    .PERIODO_SEG(PERIODO_SEG)
  ) u_cronometro (
    .clock_in(clock_in),
    .reset   (reset),
    .i_carga (w_carregaTempo),
    .i_dec   (w_decTempo),
    .o_valor (w_tempo),
    .o_zero  (w_tempoZero)
  );

`ifdef DESLIGA_POSSE_EN
  assign w_posseDesligada = (w_tempo < TEMPO_W'(TEMPO_POSSE)) &&
                            (w_tempo < {{(TEMPO_W-5){1'b0}}, contagem24});
`else
  assign w_posseDesligada = 1'b0;
`endif

  assign w_comeca   = iniciar && !pausar;
  assign w_decTempo = (r_estado == CORRENDO) && tick_1s;

  // Next-state selection plus the one-cycle requests for reload, period advance and shot-clock reload.
  always_comb begin
    w_proximo      = r_estado;
    w_pulso24      = 1'b0;
    w_carregaTempo = 1'b0;
    w_avancaQuarto = 1'b0;
    case (r_estado)
      PARADO: begin
        if (w_comeca) begin
          w_proximo = CORRENDO;
          w_pulso24 = 1'b1;
        end
      end
      CORRENDO: begin
        if (w_tempoZero) begin
          w_proximo = FIM_QUARTO;
        end else if ((contagem24 == 5'd0) && !w_posseDesligada) begin
          w_proximo = VIOLACAO;
        end else if (pausar) begin
          w_proximo = PAUSADO;
        end
        if (troca_posse) begin
          w_pulso24 = 1'b1;
        end
      end
      PAUSADO: begin
        if (w_comeca) begin
          w_proximo = CORRENDO;
        end
        if (troca_posse) begin
          w_pulso24 = 1'b1;
        end
      end
      VIOLACAO: begin
        if (troca_posse || w_comeca) begin
          w_pulso24 = 1'b1;
        end
        if (w_comeca) begin
          w_proximo = CORRENDO;
        end
      end
      FIM_QUARTO: begin
        if (w_comeca) begin
          if (r_quarto == ULTIMO_QUARTO) begin
            w_proximo = FIM_JOGO;
          end else begin
            w_proximo      = PARADO;
            w_carregaTempo = 1'b1;
            w_avancaQuarto = 1'b1;
          end
        end
      end
      FIM_JOGO: begin
        w_proximo = FIM_JOGO;
      end
      default: begin
        w_proximo = PARADO;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_estado <= PARADO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Period index, advanced only when a period closes and more remain.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_quarto <= 2'd0;
    end else if (w_avancaQuarto) begin
      r_quarto <= r_quarto + 2'd1;
    end
  end

  // Shot-clock reload pulse, delayed one cycle from its cause.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_reset24 <= 1'b0;
    end else begin
      r_reset24 <= w_pulso24;
    end
  end

  // Horn length counter; a new event reloads it even while it is still running.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_buzzCnt <= 2'd0;
    end else if (evento_buzzer(r_estado, w_proximo)) begin
      r_buzzCnt <= BUZZER_CARGA;
    end else if (r_buzzCnt != 2'd0) begin
      r_buzzCnt <= r_buzzCnt - 2'd1;
    end
  end

  assign en24       = tick_1s && (r_estado == CORRENDO) && !w_posseDesligada;
  assign parar24    = (r_estado != CORRENDO) || w_posseDesligada;
  assign reset24    = r_reset24;
  assign tempo_jogo = w_tempo;
  assign quarto     = r_quarto;
  assign estado     = r_estado;
  assign buzzer     = (r_buzzCnt != 2'd0);

endmodule

// File: tb/tb_controlador_partida.sv
// Self-checking bench for controlador_partida: a table of hand-computed vectors,
// directed multi-cycle sequences and a randomized run against a behavioural model.
module tb_controlador_partida;
  import controlador_partida_pkg::*;

  localparam int PER = 600;
  localparam int NQ  = 4;

  logic       clock_in = 1'b0;
  logic       reset, tick_1s, iniciar, pausar, troca_posse;
  logic [4:0] contagem24;
  logic       en24, parar24, reset24, buzzer;
  logic [9:0] tempo_jogo;
  logic [1:0] quarto;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the game, kept as plain integers.
  estado_t mEst   = PARADO;
  int      mTempo = PER;
  int      mQuarto = 0;
  int      mBuzz  = 0;
  bit      mR24   = 1'b0;

  typedef struct {
    bit         rst, ini, pau, troca, tick;
    logic [4:0] c24;
    estado_t    expEst;
    int         expTempo;
    int         expQuarto;
    bit         expR24, expBuzz, expEn24;
  } vetor_t;

  vetor_t tabela[19];

  controlador_partida #(
    .PERIODO_SEG(PER),
    .NUM_QUARTOS(NQ)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .tick_1s    (tick_1s),
    .iniciar    (iniciar),
    .pausar     (pausar),
    .troca_posse(troca_posse),
    .contagem24 (contagem24),
    .en24       (en24),
    .parar24    (parar24),
    .reset24    (reset24),
    .tempo_jogo (tempo_jogo),
    .quarto     (quarto),
    .estado     (estado),
    .buzzer     (buzzer)
  );

  always #5 clock_in = ~clock_in;

  function automatic vetor_t mk(input bit r, i, p, t, k, input int c, input estado_t e,
                                input int tp, input int q, input bit r24, bz, en);
    vetor_t v;
    v.rst = r; v.ini = i; v.pau = p; v.troca = t; v.tick = k; v.c24 = 5'(c);
    v.expEst = e; v.expTempo = tp; v.expQuarto = q;
    v.expR24 = r24; v.expBuzz = bz; v.expEn24 = en;
    return v;
  endfunction

  function automatic bit modelOff(input int c);
    bit off;
    off = (mTempo < TEMPO_POSSE) && (mTempo < c);
`ifndef DESLIGA_POSSE_EN
    off = 1'b0;
`endif
    return off;
  endfunction

  function automatic bit modelEn24(input bit k, input int c);
    return k && (mEst == CORRENDO) && !modelOff(c);
  endfunction

  task automatic checkVal(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Advance the model by one clock edge using the game rules.
  task automatic modelStep(input bit r, i, p, t, k, input logic [4:0] c);
    estado_t nxt;
    bit      pulso;
    bit      comeca;
    if (r) begin
      mEst = PARADO; mTempo = PER; mQuarto = 0; mBuzz = 0; mR24 = 1'b0;
      return;
    end
    comeca = i && !p;
    nxt    = mEst;
    pulso  = t && (mEst inside {CORRENDO, PAUSADO, VIOLACAO});
    case (mEst)
      PARADO:     if (comeca) begin nxt = CORRENDO; pulso = 1'b1; end
      CORRENDO: begin
        if (mTempo == 0) nxt = FIM_QUARTO;
        else if (c == 5'd0 && !modelOff(int'(c))) nxt = VIOLACAO;
        else if (p) nxt = PAUSADO;
      end
      PAUSADO:    if (comeca) nxt = CORRENDO;
      VIOLACAO:   if (comeca) begin nxt = CORRENDO; pulso = 1'b1; end
      FIM_QUARTO: begin
        if (comeca) begin
          if (mQuarto == NQ - 1) nxt = FIM_JOGO;
          else begin nxt = PARADO; mQuarto++; mTempo = PER; end
        end
      end
      default: nxt = mEst;
    endcase
    if (mEst == CORRENDO && k && mTempo > 0) mTempo--;
    if (nxt != mEst && (nxt inside {VIOLACAO, FIM_QUARTO, FIM_JOGO})) mBuzz = BUZZER_CICLOS;
    else if (mBuzz > 0) mBuzz--;
    mR24 = pulso;
    mEst = nxt;
  endtask

  task automatic driveInputs(input bit r, i, p, t, k, input logic [4:0] c);
    @(negedge clock_in);
    reset = r; iniciar = i; pausar = p; troca_posse = t; tick_1s = k; contagem24 = c;
    #1;
  endtask

  task automatic finishCycle(input bit r, i, p, t, k, input logic [4:0] c);
    modelStep(r, i, p, t, k, c);
    @(posedge clock_in);
    #1;
  endtask

  task automatic applyStimulus(input bit r, i, p, t, k, input logic [4:0] c);
    driveInputs(r, i, p, t, k, c);
    checkVal("en24", int'(en24), int'(modelEn24(k, int'(c))));
    finishCycle(r, i, p, t, k, c);
  endtask

  task automatic checkOutput();
    checkVal("estado", int'(estado), int'(mEst));
    checkVal("tempo_jogo", int'(tempo_jogo), mTempo);
    checkVal("quarto", int'(quarto), mQuarto);
    checkVal("reset24", int'(reset24), int'(mR24));
    checkVal("buzzer", int'(buzzer), (mBuzz > 0) ? 1 : 0);
    checkVal("parar24", int'(parar24),
             ((mEst != CORRENDO) || modelOff(int'(contagem24))) ? 1 : 0);
  endtask

  task automatic cycleChecked(input bit r, i, p, t, k, input logic [4:0] c);
    applyStimulus(r, i, p, t, k, c);
    checkOutput();
  endtask

  initial begin
    bit         rr, ri, rp, rt, rk;
    logic [4:0] rc;

    //                rst ini pau trc tck c24  estado      tempo q r24 bz en
    tabela[0]  = mk(1, 0, 0, 0, 0, 20, PARADO,     600, 0, 0, 0, 0);
    tabela[1]  = mk(0, 1, 0, 0, 0, 20, CORRENDO,   600, 0, 1, 0, 0);
    tabela[2]  = mk(0, 0, 0, 0, 1, 20, CORRENDO,   599, 0, 0, 0, 1);
    tabela[3]  = mk(0, 0, 0, 0, 1, 20, CORRENDO,   598, 0, 0, 0, 1);
    tabela[4]  = mk(0, 0, 0, 0, 1, 20, CORRENDO,   597, 0, 0, 0, 1);
    tabela[5]  = mk(0, 0, 0, 0, 1, 20, CORRENDO,   596, 0, 0, 0, 1);
    tabela[6]  = mk(0, 0, 0, 0, 1, 20, CORRENDO,   595, 0, 0, 0, 1);
    tabela[7]  = mk(0, 0, 0, 0, 0, 20, CORRENDO,   595, 0, 0, 0, 0);
    tabela[8]  = mk(0, 0, 1, 1, 0, 20, PAUSADO,    595, 0, 1, 0, 0);
    tabela[9]  = mk(0, 0, 0, 0, 1, 20, PAUSADO,    595, 0, 0, 0, 0);
    tabela[10] = mk(0, 1, 1, 0, 0, 20, PAUSADO,    595, 0, 0, 0, 0);
    tabela[11] = mk(0, 1, 0, 0, 0, 20, CORRENDO,   595, 0, 0, 0, 0);
    tabela[12] = mk(0, 0, 0, 1, 0, 20, CORRENDO,   595, 0, 1, 0, 0);
    tabela[13] = mk(0, 0, 0, 0, 0,  0, VIOLACAO,   595, 0, 0, 1, 0);
    tabela[14] = mk(0, 0, 0, 0, 0,  5, VIOLACAO,   595, 0, 0, 1, 0);
    tabela[15] = mk(0, 0, 0, 0, 0,  5, VIOLACAO,   595, 0, 0, 1, 0);
    tabela[16] = mk(0, 0, 0, 0, 0,  5, VIOLACAO,   595, 0, 0, 0, 0);
    tabela[17] = mk(0, 1, 0, 0, 0,  5, CORRENDO,   595, 0, 1, 0, 0);
    tabela[18] = mk(1, 1, 0, 0, 0,  5, PARADO,     600, 0, 0, 0, 0);

    reset = 1'b1; iniciar = 1'b0; pausar = 1'b0; troca_posse = 1'b0;
    tick_1s = 1'b0; contagem24 = 5'd20;
    repeat (2) @(posedge clock_in);
    modelStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd20);

    $display("[TB] table vectors");
    for (int n = 0; n < 19; n++) begin
      driveInputs(tabela[n].rst, tabela[n].ini, tabela[n].pau, tabela[n].troca,
                  tabela[n].tick, tabela[n].c24);
      checkVal($sformatf("v%0d_en24", n), int'(en24), int'(tabela[n].expEn24));
      finishCycle(tabela[n].rst, tabela[n].ini, tabela[n].pau, tabela[n].troca,
                  tabela[n].tick, tabela[n].c24);
      checkVal($sformatf("v%0d_estado", n), int'(estado), int'(tabela[n].expEst));
      checkVal($sformatf("v%0d_tempo", n), int'(tempo_jogo), tabela[n].expTempo);
      checkVal($sformatf("v%0d_quarto", n), int'(quarto), tabela[n].expQuarto);
      checkVal($sformatf("v%0d_reset24", n), int'(reset24), int'(tabela[n].expR24));
      checkVal($sformatf("v%0d_buzzer", n), int'(buzzer), int'(tabela[n].expBuzz));
      checkVal($sformatf("v%0d_parar24", n), int'(parar24),
               (tabela[n].expEst != CORRENDO) ? 1 : 0);
    end

    $display("[TB] violation at tempo 300");
    cycleChecked(0, 1, 0, 0, 0, 5'd20);
    for (int n = 0; n < 300; n++) cycleChecked(0, 0, 0, 0, 1, 5'd20);
    checkVal("tempo_300", int'(tempo_jogo), 300);
    cycleChecked(0, 0, 0, 0, 0, 5'd0);
    checkVal("viol_estado", int'(estado), int'(VIOLACAO));
    checkVal("viol_buzzer", int'(buzzer), 1);
    checkVal("viol_parar24", int'(parar24), 1);
    for (int n = 0; n < 3; n++) cycleChecked(0, 0, 0, 0, 0, 5'd20);
    cycleChecked(0, 1, 0, 0, 0, 5'd20);
    checkVal("viol_retoma_r24", int'(reset24), 1);
    checkVal("viol_retoma_estado", int'(estado), int'(CORRENDO));

    $display("[TB] period end beats violation");
    for (int n = 0; n < 299; n++) cycleChecked(0, 0, 0, 0, 1, 5'd20);
    cycleChecked(0, 0, 0, 0, 1, 5'd5);
    checkVal("tempo_zero", int'(tempo_jogo), 0);
    cycleChecked(0, 0, 0, 0, 0, 5'd0);
    checkVal("fq_estado", int'(estado), int'(FIM_QUARTO));
    checkVal("fq_buzzer", int'(buzzer), 1);
    cycleChecked(0, 1, 0, 0, 0, 5'd20);
    checkVal("fq_parado", int'(estado), int'(PARADO));
    checkVal("fq_quarto", int'(quarto), 1);
    checkVal("fq_tempo", int'(tempo_jogo), 600);

    $display("[TB] remaining periods to game end");
    for (int q = 1; q < NQ; q++) begin
      cycleChecked(0, 1, 0, 0, 0, 5'd20);
      for (int n = 0; n < PER; n++) cycleChecked(0, 0, 0, 0, 1, 5'd20);
      cycleChecked(0, 0, 0, 0, 0, 5'd20);
      cycleChecked(0, 1, 0, 0, 0, 5'd20);
    end
    checkVal("fj_estado", int'(estado), int'(FIM_JOGO));
    checkVal("fj_quarto", int'(quarto), NQ - 1);
    cycleChecked(0, 1, 0, 0, 0, 5'd20);
    cycleChecked(0, 0, 0, 1, 1, 5'd0);
    cycleChecked(0, 1, 1, 1, 1, 5'd20);
    checkVal("fj_absorve", int'(estado), int'(FIM_JOGO));
    checkVal("fj_sem_r24", int'(reset24), 0);
    cycleChecked(1, 1, 0, 0, 0, 5'd20);
    checkVal("fj_reset_estado", int'(estado), int'(PARADO));
    checkVal("fj_reset_quarto", int'(quarto), 0);

    $display("[TB] low game time with large shot clock");
    cycleChecked(0, 1, 0, 0, 0, 5'd20);
    for (int n = 0; n < 590; n++) cycleChecked(0, 0, 0, 0, 1, 5'd23);
    checkVal("tempo_10", int'(tempo_jogo), 10);
    for (int n = 0; n < 3; n++) begin
      cycleChecked(0, 0, 0, 0, 1, 5'd15);
`ifdef DESLIGA_POSSE_EN
      checkVal("desliga_en24", int'(en24), 0);
      checkVal("desliga_parar24", int'(parar24), 1);
`else
      checkVal("segue_en24", int'(en24), 1);
      checkVal("segue_parar24", int'(parar24), 0);
`endif
    end
    checkVal("baixo_estado", int'(estado), int'(CORRENDO));

    $display("[TB] randomized run");
    cycleChecked(1, 0, 0, 0, 0, 5'd20);
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(299) == 0);
      ri = ($urandom_range(7) == 0);
      rp = ($urandom_range(15) == 0);
      rt = ($urandom_range(7) == 0);
      rk = ($urandom_range(1) == 0);
      rc = ($urandom_range(19) == 0) ? 5'd0 : 5'($urandom_range(24, 1));
      cycleChecked(rr, ri, rp, rt, rk, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
